// File: rtl/blake2_ctrl_pkg.sv
// Shared encodings for the blake2 message feeder: FSM states, core command codes, block geometry.
package blake2_ctrl_pkg;

    localparam int DEF_BLOCK_BYTES = 128;
    localparam int BLOCK_BITS      = 8 * DEF_BLOCK_BYTES;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ISSUE,
        GAP,
        FINAL,
        WAIT_DGST,
        DONE,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_INIT,
        CMD_NEXT,
        CMD_FINAL
    } cmd_t;

    // Bit offset of byte slot idx; slot 0 sits in the most significant byte.
    function automatic int byte_lsb(input int block_bytes, input int idx);
        return 8 * (block_bytes - 1 - idx);
    endfunction

endpackage

// File: rtl/blake2_block_packer.sv
// Packs a byte stream into one block register, first byte in the top byte; clear zeroes it for the next block.
module blake2_block_packer
    import blake2_ctrl_pkg::*;
#(
    parameter int BLOCK_BYTES = 128,
    localparam int BITS  = 8 * BLOCK_BYTES,
    localparam int IDX_W = $clog2(BLOCK_BYTES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [7:0]       wr_byte,
    output logic [BITS-1:0]  block,
    output logic [IDX_W-1:0] idx,
    output logic             full
);

    localparam int LSB_W = $clog2(BITS);

    logic [LSB_W-1:0] lsb;

    assign full = (idx == IDX_W'(BLOCK_BYTES));

    always_comb begin
        lsb = LSB_W'(byte_lsb(BLOCK_BYTES, int'(idx)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            block <= '0;
            idx   <= '0;
        end else if (clear) begin
            block <= '0;
            idx   <= '0;
        end else if (wr_en && !full) begin
            block[lsb +: 8] <= wr_byte;
            idx             <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/blake2_msg_feeder.sv
// Drives the blake2 core command interface from a byte stream and returns the digest on a valid/ready port.
// Optional watchdog on core waits: define BLAKE2_TIMEOUT_EN.
module blake2_msg_feeder
    import blake2_ctrl_pkg::*;
#(
    parameter int BLOCK_BYTES = BLOCK_BITS / 8,
    parameter int LEN_W       = 128,
    parameter int DIGEST_W    = 88,
    parameter int MAX_BLOCKS  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               s_data,
    input  logic                     s_valid,
    input  logic                     s_last,
    output logic                     s_ready,
    input  logic                     s_empty,
    input  logic                     core_ready,
    output logic                     core_init,
    output logic                     core_next,
    output logic                     core_final,
    output logic [8*BLOCK_BYTES-1:0] core_block,
    output logic [LEN_W-1:0]         core_length,
    input  logic                     core_dvalid,
    input  logic [DIGEST_W-1:0]      core_digest,
    output logic [DIGEST_W-1:0]      m_digest,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     err,
    output state_t                   dbg_state
);

    // Handshakes: a byte moves when s_valid && s_ready at a rising edge; the digest
    // leaves when m_valid && m_ready; a core command is issued only while core_ready is high.

    localparam int IDX_W = $clog2(BLOCK_BYTES + 1);
    localparam int BC_W  = $clog2(MAX_BLOCKS + 1);

    state_t                   state;
    cmd_t                     cmd_q;
    logic [LEN_W-1:0]         len_cnt;
    logic [BC_W-1:0]          blk_cnt;
    logic                     msg_end;
    logic [8*BLOCK_BYTES-1:0] pk_block;
    logic [IDX_W-1:0]         pk_idx;
    logic                     pk_full;
    logic                     pk_clear;
    logic                     accept;
    logic                     overflow;
    logic                     wr_byte_en;
    logic                     blk_done;

    blake2_block_packer #(
        .BLOCK_BYTES(BLOCK_BYTES)
    ) u_packer (
        .clk    (clk),
        .reset  (reset),
        .clear  (pk_clear),
        .wr_en  (wr_byte_en),
        .wr_byte(s_data),
        .block  (pk_block),
        .idx    (pk_idx),
        .full   (pk_full)
    );

    always_comb begin
        accept     = s_valid && s_ready && !pk_full && (state == IDLE || state == FILL);
        // A byte arriving with an empty packer after MAX_BLOCKS blocks would open one block too many.
        overflow   = accept && (state == FILL) && (pk_idx == '0) && (blk_cnt == BC_W'(MAX_BLOCKS));
        wr_byte_en = accept && !overflow;
        blk_done   = wr_byte_en && (s_last || pk_idx == IDX_W'(BLOCK_BYTES - 1));
        pk_clear   = (state == ISSUE) && core_ready;
    end

`ifdef BLAKE2_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_wait;
    logic            wd_expire;

    always_comb begin
        wd_wait   = ((state == ISSUE || state == FINAL) && !core_ready) ||
                    (state == WAIT_DGST && !core_dvalid);
        wd_expire = wd_wait && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (wd_wait) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end else begin
            wd_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cmd_q       <= CMD_NONE;
            s_ready     <= 1'b0;
            core_block  <= '0;
            core_length <= '0;
            len_cnt     <= '0;
            blk_cnt     <= '0;
            msg_end     <= 1'b0;
            m_digest    <= '0;
            m_valid     <= 1'b0;
            err         <= 1'b0;
        end else begin
            cmd_q <= CMD_NONE;
            if (wr_byte_en) begin
                len_cnt <= len_cnt + LEN_W'(1);
            end
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (wr_byte_en) begin
                        if (blk_done) begin
                            state   <= ISSUE;
                            s_ready <= 1'b0;
                            msg_end <= s_last;
                        end else begin
                            state <= FILL;
                        end
                    end else if (s_empty) begin
                        state   <= ISSUE;
                        s_ready <= 1'b0;
                        msg_end <= 1'b1;
                    end
                end
                FILL: begin
                    if (overflow) begin
                        state   <= HALT;
                        s_ready <= 1'b0;
                        err     <= 1'b1;
                    end else if (blk_done) begin
                        state   <= ISSUE;
                        s_ready <= 1'b0;
                        msg_end <= s_last;
                    end
                end
                ISSUE: begin
                    if (core_ready) begin
                        cmd_q      <= (blk_cnt == '0) ? CMD_INIT : CMD_NEXT;
                        blk_cnt    <= blk_cnt + BC_W'(1);
                        core_block <= pk_block;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    if (msg_end) begin
                        state <= FINAL;
                    end else begin
                        state   <= FILL;
                        s_ready <= 1'b1;
                    end
                end
                FINAL: begin
                    if (core_ready) begin
                        cmd_q       <= CMD_FINAL;
                        core_length <= len_cnt;
                        state       <= WAIT_DGST;
                    end
                end
                WAIT_DGST: begin
                    if (core_dvalid) begin
                        m_digest <= core_digest;
                        m_valid  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        len_cnt <= '0;
                        blk_cnt <= '0;
                        msg_end <= 1'b0;
                        state   <= IDLE;
                    end
                end
                HALT: begin
                    s_ready <= 1'b0;
                end
            endcase
`ifdef BLAKE2_TIMEOUT_EN
            if (wd_expire) begin
                state   <= HALT;
                s_ready <= 1'b0;
                err     <= 1'b1;
            end
`endif
        end
    end

    assign core_init  = (cmd_q == CMD_INIT);
    assign core_next  = (cmd_q == CMD_NEXT);
    assign core_final = (cmd_q == CMD_FINAL);
    assign dbg_state  = state;

endmodule
